// File: rtl/cu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package cu_pkg;

  localparam logic [2:0] CU_MUL    = 3'd0;
  localparam logic [2:0] CU_MULH   = 3'd1;
  localparam logic [2:0] CU_MULHSU = 3'd2;
  localparam logic [2:0] CU_MULHU  = 3'd3;
  localparam logic [2:0] CU_DIV    = 3'd4;
  localparam logic [2:0] CU_DIVU   = 3'd5;
  localparam logic [2:0] CU_REM    = 3'd6;
  localparam logic [2:0] CU_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } cu_state_t;

  localparam logic [31:0] CU_DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] CU_OVF_QUOT  = 32'h8000_0000;
  localparam logic [31:0] CU_OVF_REM   = 32'h0000_0000;

  // Two's-complement magnitude; 0x80000000 maps to 2^31 as an unsigned value.
  function automatic logic [31:0] cu_mag(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/cu_div_core.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step.
module cu_div_core
  import cu_pkg::*;
(
  input  logic        cpu_clk_i,
  input  logic        cpu_rst_i,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] div_q;
  logic [32:0] shifted;
  logic [33:0] diff;

  // Quotient register doubles as the dividend shift register.
  assign shifted = {remainder, quotient[31]};
  assign diff    = {1'b0, shifted} - {2'b00, div_q};

  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) begin
      quotient  <= '0;
      remainder <= '0;
      div_q     <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      div_q     <= divisor;
    end else if (step) begin
      if (!diff[33]) begin
        remainder <= diff[31:0];
        quotient  <= {quotient[30:0], 1'b1};
      end else begin
        remainder <= shifted[31:0];
        quotient  <= {quotient[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/complex_unit.sv
// Iterative RV32M multiply/divide engine with single-cycle result strobe.
//   state | meaning
//   IDLE  | waiting for a request
//   CALC  | one multiply/divide iteration per edge
//   FIX   | sign correction, result select, strobe
module complex_unit
  import cu_pkg::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 2,
  parameter int DIV_ITERATIONS     = 32
) (
  input  logic        cpu_clk_i,
  input  logic        cpu_rst_i,
  input  logic        flush_i,
  input  logic        cu_valid_i,
  input  logic [2:0]  cu_opcode_i,
  input  logic [31:0] cu_operand1_i,
  input  logic [31:0] cu_operand2_i,
  output logic        busy_o,
  output logic [31:0] result_o,
  output logic        wb_valid_o
);

  localparam int          MB      = MUL_BITS_PER_CYCLE;
  localparam logic [5:0]  N_MUL_C = 6'(32 / MUL_BITS_PER_CYCLE);
  localparam logic [5:0]  N_DIV_C = 6'(DIV_ITERATIONS);

  cu_state_t   state;
  logic [5:0]  cnt;
  logic [2:0]  op_q;
  logic        neg_q;
  logic        special_q;
  logic [31:0] special_val_q;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;

  logic        is_div_in, sgn_a_in, sgn_b_in, div0_in, ovf_in, special_in, neg_in, accept;
  logic [31:0] mag_a_in, mag_b_in, special_val_in;
  logic [63:0] mul_sum, mul_fixed;
  logic [31:0] quot, rem, q_fix, r_fix, fix_val;

  assign is_div_in = cu_opcode_i[2];
  assign sgn_a_in  = cu_operand1_i[31] &&
                     (cu_opcode_i != CU_MULHU) && (cu_opcode_i != CU_DIVU) && (cu_opcode_i != CU_REMU);
  assign sgn_b_in  = cu_operand2_i[31] &&
                     ((cu_opcode_i == CU_MUL) || (cu_opcode_i == CU_MULH) ||
                      (cu_opcode_i == CU_DIV) || (cu_opcode_i == CU_REM));
  assign mag_a_in  = cu_mag(cu_operand1_i, sgn_a_in);
  assign mag_b_in  = cu_mag(cu_operand2_i, sgn_b_in);
  assign neg_in    = (cu_opcode_i == CU_REM) ? sgn_a_in : (sgn_a_in ^ sgn_b_in);

  assign div0_in    = is_div_in && (cu_operand2_i == 32'd0);
  assign ovf_in     = ((cu_opcode_i == CU_DIV) || (cu_opcode_i == CU_REM)) &&
                      (cu_operand1_i == 32'h8000_0000) && (cu_operand2_i == 32'hFFFF_FFFF);
  assign special_in = div0_in || ovf_in;
  assign special_val_in = div0_in ? (cu_opcode_i[1] ? cu_operand1_i : CU_DIV0_QUOT)
                                  : (cu_opcode_i[1] ? CU_OVF_REM : CU_OVF_QUOT);

  assign accept = cu_valid_i && !flush_i && (state == IDLE);

  always_comb begin
    mul_sum = acc;
    for (int j = 0; j < MB; j++) begin
      if (mplier[j]) mul_sum = mul_sum + (mcand << j);
    end
  end

  cu_div_core u_div (
    .cpu_clk_i (cpu_clk_i),
    .cpu_rst_i (cpu_rst_i),
    .load      (accept && is_div_in && !special_in),
    .step      ((state == CALC) && op_q[2] && !flush_i),
    .dividend  (mag_a_in),
    .divisor   (mag_b_in),
    .quotient  (quot),
    .remainder (rem)
  );

  assign mul_fixed = neg_q ? (~acc + 64'd1) : acc;
  assign q_fix     = neg_q ? (~quot + 32'd1) : quot;
  assign r_fix     = neg_q ? (~rem + 32'd1) : rem;

  always_comb begin
    if (special_q)     fix_val = special_val_q;
    else if (!op_q[2]) fix_val = (op_q == CU_MUL) ? mul_fixed[31:0] : mul_fixed[63:32];
    else               fix_val = op_q[1] ? r_fix : q_fix;
  end

  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      op_q          <= '0;
      neg_q         <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      acc           <= '0;
      mcand         <= '0;
      mplier        <= '0;
      busy_o        <= 1'b0;
      wb_valid_o    <= 1'b0;
      result_o      <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      if (flush_i) begin
        state  <= IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cu_valid_i) begin
              op_q          <= cu_opcode_i;
              neg_q         <= neg_in;
              special_q     <= special_in;
              special_val_q <= special_val_in;
              acc           <= '0;
              mcand         <= {32'd0, mag_a_in};
              mplier        <= mag_b_in;
              busy_o        <= 1'b1;
              cnt           <= is_div_in ? N_DIV_C : N_MUL_C;
              state         <= special_in ? FIX : CALC;
            end
          end
          CALC: begin
            if (!op_q[2]) begin
              acc    <= mul_sum;
              mcand  <= mcand << MB;
              mplier <= mplier >> MB;
            end
            cnt <= cnt - 6'd1;
            if (cnt == 6'd1) state <= FIX;
          end
          FIX: begin
            result_o   <= fix_val;
            wb_valid_o <= 1'b1;
            busy_o     <= 1'b0;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  a_no_req_while_busy: assert property (@(posedge cpu_clk_i) disable iff (cpu_rst_i)
    !(cu_valid_i && !flush_i && (state != IDLE)))
    else $error("cu_valid_i asserted while complex_unit is busy");

endmodule

// File: tb/tb_complex_unit.sv
// Directed self-checking bench for complex_unit.
module tb_complex_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        valid;
  logic [2:0]  opcode;
  logic [31:0] op1, op2;
  logic        busy;
  logic [31:0] result;
  logic        wb_valid;

  int checks = 0;
  int errors = 0;

  complex_unit dut (
    .cpu_clk_i     (clk),
    .cpu_rst_i     (rst),
    .flush_i       (flush),
    .cu_valid_i    (valid),
    .cu_opcode_i   (opcode),
    .cu_operand1_i (op1),
    .cu_operand2_i (op2),
    .busy_o        (busy),
    .result_o      (result),
    .wb_valid_o    (wb_valid)
  );

  always #5 clk = ~clk;

  // Drive a request from posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    opcode = op; op1 = a; op2 = b; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_wb(input int limit, output int edges, output logic [31:0] res, output logic busy_at);
    edges = 0; res = 'x; busy_at = 'x;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (wb_valid) begin
        edges = i; res = result; busy_at = busy;
        break;
      end
    end
  endtask

  task automatic test_reset;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb got %b want 0", wb_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
  endtask

  task automatic test_mul;
    int e; logic [31:0] r; logic b;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy got %b want 1", busy); end
    wait_wb(60, e, r, b);
    checks++; if (e !== 17) begin errors++; $display("FAIL mul_latency got %0d want 17", e); end
    checks++; if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result got %h want ffffffeb", r); end
    checks++; if (b !== 1'b0) begin errors++; $display("FAIL mul_busy_at_wb got %b want 0", b); end
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mul_wb_width got %b want 0", wb_valid); end
    checks++; if (result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_hold got %h want ffffffeb", result); end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  ops [3] = '{3'd1, 3'd3, 3'd2};
    logic [31:0] as  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int e; logic [31:0] r; logic b;
    issue(ops[0], as[0], bs[0]);
    for (int i = 0; i < 3; i++) begin
      wait_wb(60, e, r, b);
      checks++; if (e !== 17) begin errors++; $display("FAIL b2b_latency[%0d] got %0d want 17", i, e); end
      checks++; if (r !== exp[i]) begin errors++; $display("FAIL b2b_result[%0d] got %h want %h", i, r, exp[i]); end
      if (i < 2) issue(ops[i+1], as[i+1], bs[i+1]);
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int e; logic [31:0] r; logic b;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_wb(80, e, r, b);
      checks++; if (e !== 33) begin errors++; $display("FAIL div_latency[%0d] got %0d want 33", i, e); end
      checks++; if (r !== exp[i]) begin errors++; $display("FAIL div_result[%0d] got %h want %h", i, r, exp[i]); end
    end
  endtask

  task automatic test_special;
    logic [2:0]  ops [4] = '{3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int e; logic [31:0] r; logic b;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_wb(40, e, r, b);
      checks++; if (e !== 1) begin errors++; $display("FAIL special_latency[%0d] got %0d want 1", i, e); end
      checks++; if (r !== exp[i]) begin errors++; $display("FAIL special_result[%0d] got %h want %h", i, r, exp[i]); end
    end
  endtask

  task automatic test_flush;
    int e; logic [31:0] r; logic b;
    issue(3'd4, 32'd100, 32'd7);
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    wait_wb(50, e, r, b);
    checks++; if (e !== 0) begin errors++; $display("FAIL flush_no_wb got strobe at %0d want none", e); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL flush_result_hold got %h want 0", result); end
    issue(3'd0, 32'd3, 32'd4);
    wait_wb(60, e, r, b);
    checks++; if (e !== 17) begin errors++; $display("FAIL post_flush_latency got %0d want 17", e); end
    checks++; if (r !== 32'd12) begin errors++; $display("FAIL post_flush_result got %h want c", r); end
    flush = 1'b1;
    issue(3'd4, 32'd9, 32'd3);
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_valid_busy got %b want 0", busy); end
    wait_wb(50, e, r, b);
    checks++; if (e !== 0) begin errors++; $display("FAIL flush_valid_no_wb got strobe at %0d want none", e); end
    checks++; if (result !== 32'd12) begin errors++; $display("FAIL flush_valid_hold got %h want c", result); end
  endtask

  task automatic test_async_reset;
    int e; logic [31:0] r; logic b;
    issue(3'd0, 32'd5, 32'd6);
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b want 1", busy); end
    #3 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy got %b want 0", busy); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL async_rst_wb got %b want 0", wb_valid); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL async_rst_result got %h want 0", result); end
    @(posedge clk); #1;
    rst = 1'b0;
    issue(3'd4, 32'd9, 32'd3);
    wait_wb(80, e, r, b);
    checks++; if (e !== 33) begin errors++; $display("FAIL post_rst_latency got %0d want 33", e); end
    checks++; if (r !== 32'd3) begin errors++; $display("FAIL post_rst_result got %h want 3", r); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; valid = 1'b0; opcode = '0; op1 = '0; op2 = '0;
    #12;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_mul();
    test_back_to_back();
    test_div();
    test_special();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
